// File: rtl/char_pixel_renderer_if.sv
// Signal bundle between the character-row buffer, the scan generator and
// the pixel renderer. The master drives the char/scan side and observes the
// pixel/sync outputs; the slave is the renderer itself.
interface char_pixel_renderer_if;
    logic [5:0] char_code;
    logic [9:0] xcoor;
    logic [8:0] ycoor;
    logic       active;
    logic       hsync_in;
    logic       vsync_in;
    logic [6:0] cursor_col;
    logic [5:0] rgb;
    logic       hsync_out;
    logic       vsync_out;

    modport master (
        output char_code, xcoor, ycoor, active, hsync_in, vsync_in, cursor_col,
        input  rgb, hsync_out, vsync_out
    );

    modport slave (
        input  char_code, xcoor, ycoor, active, hsync_in, vsync_in, cursor_col,
        output rgb, hsync_out, vsync_out
    );
endinterface

// File: rtl/char_pixel_renderer.sv
// char_pixel_renderer: turns the 6-bit char code stream of one text row into
// RGB222 pixels using an 8x10 glyph ROM ('0'..'9', 'A'..'Z').
// Scan coordinates and syncs are delayed CHAR_LAT clocks to meet the char
// code, then pass through stage A (decode) and stage B (glyph lookup and
// pixel select), so rgb/hsync_out/vsync_out trail the scan by CHAR_LAT+2.
// Optional feature macro: CURSOR_EN adds a blinking underline cursor driven
// by a 5-bit frame counter clocked on vsync_in falling edges.
module char_pixel_renderer #(
    parameter int         CHAR_LAT = 2,
    parameter int         Y_START  = 100,
    parameter logic [5:0] FG_COLOR = 6'b111111,
    parameter logic [5:0] BG_COLOR = 6'b000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    char_pixel_renderer_if.slave   bus
);

    // One entry of the coordinate/sync delay line.
    typedef struct packed {
        logic [2:0] col;
`ifdef CURSOR_EN
        logic [6:0] xchar;
`endif
        logic [8:0] y;
        logic       act;
        logic       hs;
        logic       vs;
    } dl_t;

    // Glyph ROM: rows 1..8 of each glyph packed MSB-first (row 1 in [63:56]),
    // bit 7 of each row is the leftmost pixel. Rows 0 and 9 are empty except
    // the top bar of '0'.
    function automatic logic [7:0] glyph_row(input logic [5:0] code, input logic [8:0] row);
        logic [63:0] g;
        logic [7:0]  r;
        case (code)
            6'd0:    g = 64'h666E76666666663C;
            6'd1:    g = 64'h183818181818187E;
            6'd2:    g = 64'h3C66060C1830607E;
            6'd3:    g = 64'h3C66061C0606663C;
            6'd4:    g = 64'h0C1C2C4C7E0C0C0C;
            6'd5:    g = 64'h7E607C060606663C;
            6'd6:    g = 64'h3C60607C6666663C;
            6'd7:    g = 64'h7E060C1830303030;
            6'd8:    g = 64'h3C66663C6666663C;
            6'd9:    g = 64'h3C66663E06060C38;
            6'd10:   g = 64'h183C66667E666666;
            6'd11:   g = 64'h7C66667C6666667C;
            6'd12:   g = 64'h3C6660606060663C;
            6'd13:   g = 64'h786C666666666C78;
            6'd14:   g = 64'h7E60607C6060607E;
            6'd15:   g = 64'h7E60607C60606060;
            6'd16:   g = 64'h3C66606E6666663C;
            6'd17:   g = 64'h6666667E66666666;
            6'd18:   g = 64'h3C1818181818183C;
            6'd19:   g = 64'h1E0C0C0C0C6C6C38;
            6'd20:   g = 64'h666C7870786C6666;
            6'd21:   g = 64'h606060606060607E;
            6'd22:   g = 64'h63777F6B63636363;
            6'd23:   g = 64'h66767E7E6E666666;
            6'd24:   g = 64'h3C6666666666663C;
            6'd25:   g = 64'h7C66667C60606060;
            6'd26:   g = 64'h3C666666666E3C0E;
            6'd27:   g = 64'h7C66667C786C6666;
            6'd28:   g = 64'h3C66603C0606663C;
            6'd29:   g = 64'h7E18181818181818;
            6'd30:   g = 64'h666666666666663C;
            6'd31:   g = 64'h6666666666663C18;
            6'd32:   g = 64'h6363636B7F776363;
            6'd33:   g = 64'h66663C183C666666;
            6'd34:   g = 64'h6666663C18181818;
            6'd35:   g = 64'h7E060C183060607E;
            default: g = 64'h0000000000000000;
        endcase
        case (row)
            9'd0:    r = (code == 6'd0) ? 8'h3C : 8'h00;
            9'd1:    r = g[63:56];
            9'd2:    r = g[55:48];
            9'd3:    r = g[47:40];
            9'd4:    r = g[39:32];
            9'd5:    r = g[31:24];
            9'd6:    r = g[23:16];
            9'd7:    r = g[15:8];
            9'd8:    r = g[7:0];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    dl_t        dl_q [CHAR_LAT];
    dl_t        dl_d [CHAR_LAT];
    dl_t        dl_tail;

    // Stage A
    logic [5:0] code_q,  code_d;
    logic [2:0] col_q,   col_d;
    logic [8:0] grow_q,  grow_d;
    logic       act_q,   act_d;
    logic       hs_a_q,  hs_a_d;
    logic       vs_a_q,  vs_a_d;

    // Stage B (output registers)
    logic [5:0] rgb_q,       rgb_d;
    logic       hsync_out_q, hsync_out_d;
    logic       vsync_out_q, vsync_out_d;

    logic [7:0] row_bits;
    logic       pixel;

`ifdef CURSOR_EN
    logic [6:0] xchar_q,  xchar_d;
    logic       vs_prev_q, vs_prev_d;
    logic [4:0] blink_q,  blink_d;
    logic       cursor_hit;
`endif

    // Next-state logic for the delay line, both pipeline stages and the blink counter.
    always_comb begin
        dl_d = dl_q;
        dl_d[0].col = bus.xcoor[2:0];
`ifdef CURSOR_EN
        dl_d[0].xchar = bus.xcoor[9:3];
`endif
        dl_d[0].y   = bus.ycoor;
        dl_d[0].act = bus.active;
        dl_d[0].hs  = bus.hsync_in;
        dl_d[0].vs  = bus.vsync_in;
        for (int i = 1; i < CHAR_LAT; i++) begin
            dl_d[i] = dl_q[i-1];
        end
        dl_tail = dl_q[CHAR_LAT-1];

        // Stage A: the delay-line tail now matches char_code.
        code_d = bus.char_code;
        col_d  = dl_tail.col;
        // Lines above the row wrap to a large value and fall out of the window.
        grow_d = dl_tail.y - 9'(Y_START);
        act_d  = dl_tail.act;
        hs_a_d = dl_tail.hs;
        vs_a_d = dl_tail.vs;

        // Stage B: glyph lookup and pixel select folded into the output register.
        if ((grow_q <= 9'd9) && (code_q <= 6'd35)) begin
            row_bits = glyph_row(code_q, grow_q);
        end else begin
            row_bits = 8'h00;
        end
        pixel = row_bits[3'd7 - col_q];

`ifdef CURSOR_EN
        xchar_d   = dl_tail.xchar;
        vs_prev_d = bus.vsync_in;
        if (vs_prev_q && !bus.vsync_in) begin
            blink_d = blink_q + 5'd1;
        end else begin
            blink_d = blink_q;
        end
        // Underline on the last glyph row; columns beyond 69 are off-screen text.
        cursor_hit = blink_q[4] && (bus.cursor_col <= 7'd69) &&
                     (xchar_q == bus.cursor_col) && (grow_q == 9'd9);
        if (cursor_hit) begin
            pixel = 1'b1;
        end else begin
            pixel = pixel;
        end
`endif

        if (!act_q) begin
            rgb_d = 6'd0;
        end else if (pixel) begin
            rgb_d = FG_COLOR;
        end else begin
            rgb_d = BG_COLOR;
        end
        hsync_out_d = hs_a_q;
        vsync_out_d = vs_a_q;
    end

    // State registers; syncs idle high, everything else clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHAR_LAT; i++) begin
                dl_q[i]    <= '0;
                dl_q[i].hs <= 1'b1;
                dl_q[i].vs <= 1'b1;
            end
            code_q      <= 6'd0;
            col_q       <= 3'd0;
            grow_q      <= 9'd0;
            act_q       <= 1'b0;
            hs_a_q      <= 1'b1;
            vs_a_q      <= 1'b1;
            rgb_q       <= 6'd0;
            hsync_out_q <= 1'b1;
            vsync_out_q <= 1'b1;
`ifdef CURSOR_EN
            xchar_q     <= 7'd0;
            vs_prev_q   <= 1'b1;
            blink_q     <= 5'd0;
`endif
        end else begin
            dl_q        <= dl_d;
            code_q      <= code_d;
            col_q       <= col_d;
            grow_q      <= grow_d;
            act_q       <= act_d;
            hs_a_q      <= hs_a_d;
            vs_a_q      <= vs_a_d;
            rgb_q       <= rgb_d;
            hsync_out_q <= hsync_out_d;
            vsync_out_q <= vsync_out_d;
`ifdef CURSOR_EN
            xchar_q     <= xchar_d;
            vs_prev_q   <= vs_prev_d;
            blink_q     <= blink_d;
`endif
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.hsync_out = hsync_out_q;
    assign bus.vsync_out = vsync_out_q;

endmodule

// File: tb/tb_char_pixel_renderer.sv
// Scoreboard bench for char_pixel_renderer (default parameters).
// Each step drives one scan position; the expected pixel/syncs are pushed
// and compared four clocks later when the DUT emits them.
module tb_char_pixel_renderer;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    char_pixel_renderer_if bus_if ();

    char_pixel_renderer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    typedef struct packed {
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t       exp_q [$];
    logic [5:0] code_hist [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [4:0] fall_cnt = 5'd0;
    logic       vs_prev  = 1'b1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Known glyph rows: {known, bits}. Rows outside 0..9, row 9 and codes
    // above 35 are blank; row 0 is blank except '0'; 'A' row 1 is 8'h18.
    function automatic logic [8:0] model_row(input logic [5:0] code, input logic [8:0] grow);
        if (code > 6'd35 || grow > 9'd9) return {1'b1, 8'h00};
        if (grow == 9'd9)                return {1'b1, 8'h00};
        if (grow == 9'd0)                return {1'b1, (code == 6'd0) ? 8'h3C : 8'h00};
        if (grow == 9'd1 && code == 6'd10) return {1'b1, 8'h18};
        return {1'b0, 8'h00};
    endfunction

    // Drive one scan position (called at a negedge), queue its expectation,
    // then compare the output that emerges after the next posedge.
    task automatic step(input logic [9:0] x, input logic [8:0] y, input logic act,
                        input logic hs, input logic vs, input logic [5:0] code);
        exp_t       e;
        logic [8:0] m;
        logic [8:0] grow;
        logic       pix;
        bus_if.xcoor    = x;
        bus_if.ycoor    = y;
        bus_if.active   = act;
        bus_if.hsync_in = hs;
        bus_if.vsync_in = vs;
        code_hist.push_back(code);
        if (code_hist.size() > 2) bus_if.char_code = code_hist.pop_front();
        else                      bus_if.char_code = 6'd63;
        if (vs_prev && !vs) fall_cnt = fall_cnt + 5'd1;
        vs_prev = vs;
        grow = y - 9'd100;
        m    = model_row(code, grow);
        pix  = m[7 - int'(x[2:0])];
`ifdef CURSOR_EN
        if (fall_cnt[4] && bus_if.cursor_col <= 7'd69 && x[9:3] == bus_if.cursor_col && grow == 9'd9)
            pix = 1'b1;
`endif
        e.rgb = !act ? 6'h00 : (pix ? 6'h3F : 6'h00);
        e.hs  = hs;
        e.vs  = vs;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() >= LAT) begin
            e = exp_q.pop_front();
            check_val("rgb",       32'(bus_if.rgb),       32'(e.rgb));
            check_val("hsync_out", 32'(bus_if.hsync_out), 32'(e.hs));
            check_val("vsync_out", 32'(bus_if.vsync_out), 32'(e.vs));
        end
        @(negedge clk);
    endtask

    // Assert reset at a negedge, check outputs at once, release, and queue
    // the cleared pipeline contents that drain before new data appears.
    task automatic do_reset();
        exp_t r;
        rst_n = 1'b0;
        #1;
        check_val("rst_rgb", 32'(bus_if.rgb),       32'h00);
        check_val("rst_hs",  32'(bus_if.hsync_out), 32'h1);
        check_val("rst_vs",  32'(bus_if.vsync_out), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        code_hist.delete();
        fall_cnt = 5'd0;
        vs_prev  = 1'b1;
        r.rgb = 6'h00; r.hs = 1'b1; r.vs = 1'b1;
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back(r);
    endtask

    initial begin
        logic [9:0] rx;
        logic [8:0] ry;
        logic [5:0] rc;
        logic [8:0] mk;
        bus_if.char_code  = 6'd63;
        bus_if.xcoor      = 10'd0;
        bus_if.ycoor      = 9'd0;
        bus_if.active     = 1'b0;
        bus_if.hsync_in   = 1'b1;
        bus_if.vsync_in   = 1'b1;
        bus_if.cursor_col = 7'd127;
        @(negedge clk);
        do_reset();

        // '0' top bar and 'A' row 1
        for (int i = 0; i < 8; i++) step(10'(i), 9'd100, 1'b1, 1'b1, 1'b1, 6'd0);
        for (int i = 8; i < 16; i++) step(10'(i), 9'd101, 1'b1, 1'b1, 1'b1, 6'd10);
        // blank cases: codes 36 and 63, line above and line below the window, inactive
        for (int i = 0; i < 8; i++) step(10'(16 + i), 9'd103, 1'b1, 1'b1, 1'b1, 6'd36);
        for (int i = 0; i < 8; i++) step(10'(24 + i), 9'd104, 1'b1, 1'b1, 1'b1, 6'd63);
        for (int i = 0; i < 8; i++) step(10'(i), 9'd110, 1'b1, 1'b1, 1'b1, 6'd0);
        for (int i = 0; i < 8; i++) step(10'(i), 9'd99, 1'b1, 1'b1, 1'b1, 6'd0);
        for (int i = 0; i < 8; i++) step(10'(i), 9'd100, 1'b0, 1'b1, 1'b1, 6'd0);
        // sync latency and width
        for (int i = 0; i < 10; i++)
            step(10'(640 + i), 9'd200, 1'b0, (i >= 2 && i < 5) ? 1'b0 : 1'b1, (i >= 4 && i < 6) ? 1'b0 : 1'b1, 6'd63);

        // random scan positions, codes forced blank where the row is not pinned down
        for (int n = 0; n < 200; n++) begin
            rx = 10'($urandom_range(0, 639));
            ry = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(95, 115)) : 9'($urandom_range(0, 479));
            rc = 6'($urandom_range(0, 63));
            mk = model_row(rc, ry - 9'd100);
            if (!mk[8]) rc = 6'd63;
            step(rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rc);
        end

        // reset in the middle of lit pixels
        for (int i = 0; i < 6; i++) step(10'(2 + (i % 4)), 9'd100, 1'b1, 1'b0, 1'b1, 6'd0);
        do_reset();
        for (int i = 0; i < 10; i++) step(10'(2 + (i % 4)), 9'd100, 1'b1, 1'b1, 1'b1, 6'd0);

        // underline cursor at column 5 after 16 and 32 frame starts
        do_reset();
        bus_if.cursor_col = 7'd5;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 6'd63);
                step(10'd0, 9'd0, 1'b0, 1'b1, 1'b0, 6'd63);
            end
            for (int i = 0; i < 4; i++) step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 6'd63);
            for (int i = 0; i < 8; i++) step(10'(40 + i), 9'd109, 1'b1, 1'b1, 1'b1, 6'd63);
        end
        bus_if.cursor_col = 7'd127;

        for (int i = 0; i < LAT; i++) step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 6'd63);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
